data_memory_sized: RTL and testbench
====================================

Name: data_memory_sized

Overview:
- Parametrised successor to the CPU data memory: a word-organised RAM with RV32 byte, half-word and word loads and stores.
- Sign/zero extension on loads; byte-lane merge on stores; misalignment and illegal-funct3 detection.
- Programmable access latency with a busywait stall handshake.
- Optional clear-on-reset sweep. Sits in the MEM stage behind the pipeline's stall logic.

Parameters:
- ADDR_WIDTH, 10, byte-address width; depth = 2^(ADDR_WIDTH-2) 32-bit words (min 3).
- LATENCY, 5, number of BUSY cycles per access (min 1).
- CLEAR_ON_RESET, 1, 1 = zero every word after reset, 0 = contents retained.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- read  input  1  load request, held until busywait is seen low.
- write  input  1  store request, held until busywait is seen low.
- funct3  input  3  RV32 size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- address  input  ADDR_WIDTH  byte address.
- writedata  input  32  store data, right-aligned.
- readdata  output  32  extended load result, registered.
- busywait  output  1  stall request to the pipeline.
- access_fault  output  1  misaligned, illegal funct3, or read&&write; valid in the DONE cycle.

Behaviour:
- Clocking: one clock (clock); reset is synchronous and active-high (reset).
- Reset values: readdata=0, access_fault=0, counters=0.
  - State goes to CLEAR if CLEAR_ON_RESET=1, else IDLE.
  - An access in progress is aborted with no memory write.
- States:
  - CLEAR: one word zeroed per cycle, index 0..depth-1, busywait=1, requests not latched. After the last word -> IDLE. Takes depth cycles after reset falls.
  - IDLE: busywait = read|write (combinational). On read^write: latch address, funct3, writedata and op; cnt=LATENCY-1; -> BUSY. On read&&write: nothing latched, busywait=0, -> DONE with access_fault=1.
  - BUSY: busywait=1. When cnt!=0, decrement. When cnt==0, perform the access at this edge and -> DONE.
  - DONE: exactly one cycle, busywait=0, read/write ignored, -> IDLE. Gives the pipeline one edge to advance before a held request is re-sampled.
- Timing: total busywait-high time per access = 1 + LATENCY cycles. readdata and access_fault are valid in the DONE cycle and held until the next completed access. access_fault clears in IDLE.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else is a fault.
- Alignment:
  - H/HU requires address[0]=0.
  - W requires address[1:0]=00.
  - B/BU is always aligned.
- Faulted access: full latency, memory unchanged, readdata=0, access_fault=1.
- Loads: select the byte or half-word by address[1:0]. B/H sign-extend bit 7 or bit 15; BU/HU zero-extend.
- Stores: write only the addressed lanes (SB 1 lane, SH 2 lanes, SW 4 lanes); other lanes are unchanged.
- Byte ordering: little-endian, byte 0 = bits 7:0.
- Wrap: none. The address spans the full array exactly.
- Request changing during BUSY: ignored. The latched copy is used.

Decomposition:
- Shared package data_memory_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum {CLEAR, IDLE, BUSY, DONE}.
- Sub-module dmem_byte_align (combinational): from funct3, address[1:0], the stored word and writedata, produce the 4-bit lane enable, the merged store word, the extended load value and a fault flag.

Test Plan:
- Reset with CLEAR_ON_RESET=1, ADDR_WIDTH=6 -> busywait=1 for 16 cycles after reset falls; then LW of every word returns 0x00000000.
- SW 0x8899AABC @0x08, then LB @0x08 -> 0xFFFFFFBC; LBU @0x0B -> 0x00000088; LH @0x0A -> 0xFFFF8899.
- SB 0x55 @0x09 over the previous word -> LW @0x08 = 0x889955BC.
- LATENCY=3: read asserted at cycle 0 -> busywait high cycles 0-3, low at cycle 4 with readdata valid; a read held through cycle 5 starts a new access.
- LW @0x02, SH @0x01, funct3=011 load, read&&write -> access_fault=1 in DONE, readdata=0, memory unchanged.
- reset asserted mid-BUSY of SW 0x12345678 @0x10 (CLEAR_ON_RESET=0) -> word unchanged, readdata=0, state IDLE next cycle.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared definitions for the sized data memory: RV32 load/store size codes and FSM states.
package data_memory_pkg;

  // funct3 size/sign encodings used by loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    StClear,
    StIdle,
    StBusy,
    StDone
  } dmem_state_e;

endpackage

// File: rtl/dmem_byte_align.sv
// Byte-lane steering for the data memory: lane enables and merged word for stores,
// sign/zero-extended value for loads, and misalignment / illegal-size detection.
module dmem_byte_align
  import data_memory_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_offset,
  input  logic        store,
  input  logic [31:0] stored_word,
  input  logic [31:0] writedata,
  output logic [3:0]  lane_en,
  output logic [31:0] store_word,
  output logic [31:0] load_value,
  output logic        fault
);

  logic [31:0] shifted_word;
  logic [31:0] shifted_data;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Bring the addressed byte/half down to bit 0 for loads, and lift store data up to its lane.
  assign shifted_word = stored_word >> {byte_offset, 3'b000};
  assign shifted_data = writedata << {byte_offset, 3'b000};
  assign sel_byte     = shifted_word[7:0];
  assign sel_half     = shifted_word[15:0];

  // Decode size, check legality/alignment, then merge the enabled lanes into the old word.
  always_comb begin
    lane_en    = 4'b0000;
    load_value = 32'h0;
    fault      = 1'b0;
    store_word = stored_word;

    case (funct3)
      F3_B: begin
        lane_en    = 4'b0001 << byte_offset;
        load_value = {{24{sel_byte[7]}}, sel_byte};
      end
      F3_BU: begin
        fault      = store;
        lane_en    = 4'b0001 << byte_offset;
        load_value = {24'h0, sel_byte};
      end
      F3_H: begin
        fault      = byte_offset[0];
        lane_en    = 4'b0011 << byte_offset;
        load_value = {{16{sel_half[15]}}, sel_half};
      end
      F3_HU: begin
        fault      = store | byte_offset[0];
        lane_en    = 4'b0011 << byte_offset;
        load_value = {16'h0, sel_half};
      end
      F3_W: begin
        fault      = |byte_offset;
        lane_en    = 4'b1111;
        load_value = stored_word;
      end
      default: begin
        fault = 1'b1;
      end
    endcase

    // A faulted access touches no lanes and returns zero.
    if (fault) begin
      lane_en    = 4'b0000;
      load_value = 32'h0;
    end

    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) begin
        store_word[8*i +: 8] = shifted_data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/data_memory_sized.sv
// Word-organised data memory with RV32 byte/half/word accesses, a fixed access latency
// signalled through busywait, and an optional zeroing sweep after reset.
module data_memory_sized
  import data_memory_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned LATENCY        = 5,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  read,
  input  logic                  write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  busywait,
  output logic                  access_fault
);

  localparam int unsigned WordAw = ADDR_WIDTH - 2;
  localparam int unsigned Depth  = 1 << WordAw;
  localparam int unsigned CntW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [CntW-1:0]   CntInit = CntW'(LATENCY - 1);
  localparam logic [WordAw-1:0] LastIdx = WordAw'(Depth - 1);

  dmem_state_e state_q, state_d;

  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [WordAw-1:0]     clr_idx_q, clr_idx_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            f3_q;
  logic [31:0]           wdata_q;
  logic                  store_q;
  logic                  latch_en;
  logic [31:0]           rdata_q, rdata_d;
  logic                  fault_q, fault_d;

  logic [31:0]       mem_q [Depth];
  logic              mem_we;
  logic [WordAw-1:0] mem_idx;
  logic [31:0]       mem_wdata;

  logic [WordAw-1:0] word_idx;
  logic [31:0]       stored_word;
  logic [3:0]        lane_en;
  logic [31:0]       store_word;
  logic [31:0]       load_value;
  logic              align_fault;

  assign word_idx    = addr_q[ADDR_WIDTH-1:2];
  assign stored_word = mem_q[word_idx];

  dmem_byte_align u_byte_align (
    .funct3      (f3_q),
    .byte_offset (addr_q[1:0]),
    .store       (store_q),
    .stored_word (stored_word),
    .writedata   (wdata_q),
    .lane_en     (lane_en),
    .store_word  (store_word),
    .load_value  (load_value),
    .fault       (align_fault)
  );

  // Next-state, handshake and memory-write decode for the access sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    clr_idx_d = clr_idx_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;
    latch_en  = 1'b0;
    busywait  = 1'b0;
    mem_we    = 1'b0;
    mem_idx   = word_idx;
    mem_wdata = store_word;

    unique case (state_q)
      StClear: begin
        busywait  = 1'b1;
        mem_we    = 1'b1;
        mem_idx   = clr_idx_q;
        mem_wdata = 32'h0;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LastIdx) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (read ^ write) begin
          busywait = 1'b1;
          latch_en = 1'b1;
          cnt_d    = CntInit;
          state_d  = StBusy;
        end else if (read && write) begin
          // Contradictory request: no stall, report it straight away in DONE.
          rdata_d = 32'h0;
          fault_d = 1'b1;
          state_d = StDone;
        end
      end
      StBusy: begin
        busywait = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          mem_we  = store_q && !align_fault && (|lane_en);
          rdata_d = (!store_q && !align_fault) ? load_value : 32'h0;
          fault_d = align_fault;
          state_d = StDone;
        end
      end
      StDone: begin
        // One cycle with busywait low so the pipeline advances before a held request
        // is looked at again; the fault flag is only meaningful here.
        fault_d = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sequencer state, latency counter, clear pointer, result registers and latched request.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (CLEAR_ON_RESET) begin
        state_q <= StClear;
      end else begin
        state_q <= StIdle;
      end
      cnt_q     <= '0;
      clr_idx_q <= '0;
      rdata_q   <= 32'h0;
      fault_q   <= 1'b0;
      addr_q    <= '0;
      f3_q      <= 3'b000;
      wdata_q   <= 32'h0;
      store_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clr_idx_q <= clr_idx_d;
      rdata_q   <= rdata_d;
      fault_q   <= fault_d;
      if (latch_en) begin
        addr_q  <= address;
        f3_q    <= funct3;
        wdata_q <= writedata;
        store_q <= write;
      end
    end
  end

  // Storage array is not reset; a write due on a reset edge is dropped so an aborted
  // store leaves memory untouched.
  always_ff @(posedge clock) begin
    if (mem_we && !reset) begin
      mem_q[mem_idx] <= mem_wdata;
    end
  end

  assign readdata     = rdata_q;
  assign access_fault = fault_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: instance A clears on reset with LATENCY=3,
// instance B retains contents with LATENCY=5.
module tb_data_memory_sized;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        a_reset, a_read, a_write, a_busywait, a_access_fault;
  logic [2:0]  a_funct3;
  logic [5:0]  a_address;
  logic [31:0] a_writedata, a_readdata;

  logic        b_reset, b_read, b_write, b_busywait, b_access_fault;
  logic [2:0]  b_funct3;
  logic [5:0]  b_address;
  logic [31:0] b_writedata, b_readdata;

  int checks = 0;
  int errors = 0;

  data_memory_sized #(
    .ADDR_WIDTH     (6),
    .LATENCY        (3),
    .CLEAR_ON_RESET (1'b1)
  ) u_dut_a (
    .clock        (clock),
    .reset        (a_reset),
    .read         (a_read),
    .write        (a_write),
    .funct3       (a_funct3),
    .address      (a_address),
    .writedata    (a_writedata),
    .readdata     (a_readdata),
    .busywait     (a_busywait),
    .access_fault (a_access_fault)
  );

  data_memory_sized #(
    .ADDR_WIDTH     (6),
    .LATENCY        (5),
    .CLEAR_ON_RESET (1'b0)
  ) u_dut_b (
    .clock        (clock),
    .reset        (b_reset),
    .read         (b_read),
    .write        (b_write),
    .funct3       (b_funct3),
    .address      (b_address),
    .writedata    (b_writedata),
    .readdata     (b_readdata),
    .busywait     (b_busywait),
    .access_fault (b_access_fault)
  );

  task automatic drive(input bit sel, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [5:0] addr, input logic [31:0] wd);
    if (sel) begin
      b_read = rd; b_write = wr; b_funct3 = f3; b_address = addr; b_writedata = wd;
    end else begin
      a_read = rd; a_write = wr; a_funct3 = f3; a_address = addr; a_writedata = wd;
    end
  endtask

  // Hold a request until busywait is seen low, capture the DONE-cycle results, then release.
  task automatic access(input bit sel, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [5:0] addr, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic flt, output int bw_cnt);
    drive(sel, rd, wr, f3, addr, wd);
    bw_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if ((sel ? b_busywait : a_busywait) === 1'b1) bw_cnt++;
      else break;
    end
    rdata = sel ? b_readdata : a_readdata;
    flt   = sel ? b_access_fault : a_access_fault;
    @(posedge clock); #1;
    drive(sel, 1'b0, 1'b0, 3'b000, 6'h00, 32'h0);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        flt;
    int          bw;
    int          cnt;
    a_reset = 1'b1;
    b_reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 6'h00, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 6'h00, 32'h0);
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (a_readdata !== 32'h0) begin
      errors++; $display("FAIL reset_readdata: got %h expected %h", a_readdata, 32'h0);
    end
    checks++;
    if (a_access_fault !== 1'b0) begin
      errors++; $display("FAIL reset_fault: got %b expected 0", a_access_fault);
    end
    a_reset = 1'b0;
    b_reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (a_busywait === 1'b1) cnt++;
      else break;
    end
    checks++;
    if (cnt != 16) begin
      errors++; $display("FAIL clear_busy_cycles: got %0d expected 16", cnt);
    end
    checks++;
    if (b_busywait !== 1'b0) begin
      errors++; $display("FAIL noclear_idle_busywait: got %b expected 0", b_busywait);
    end
    @(posedge clock); #1;
    for (int w = 0; w < 16; w++) begin
      access(1'b0, 1'b1, 1'b0, LW, 6'(w * 4), 32'h0, rd, flt, bw);
      checks++;
      if (rd !== 32'h0 || flt !== 1'b0) begin
        errors++; $display("FAIL clear_word_%0d: got %h/%b expected 00000000/0", w, rd, flt);
      end
      if (w == 0) begin
        checks++;
        if (bw != 4) begin
          errors++; $display("FAIL lw_busy_cycles: got %0d expected 4", bw);
        end
      end
    end
  endtask

  task automatic test_load_store();
    logic [31:0] rd;
    logic        flt;
    int          bw;
    access(1'b0, 1'b0, 1'b1, LW, 6'h08, 32'h8899AABC, rd, flt, bw);
    checks++;
    if (flt !== 1'b0 || bw != 4) begin
      errors++; $display("FAIL sw_08: got fault %b busy %0d expected 0 / 4", flt, bw);
    end
    access(1'b0, 1'b1, 1'b0, LB, 6'h08, 32'h0, rd, flt, bw);
    checks++;
    if (rd !== 32'hFFFFFFBC) begin
      errors++; $display("FAIL lb_08: got %h expected %h", rd, 32'hFFFFFFBC);
    end
    access(1'b0, 1'b1, 1'b0, LBU, 6'h0B, 32'h0, rd, flt, bw);
    checks++;
    if (rd !== 32'h00000088) begin
      errors++; $display("FAIL lbu_0b: got %h expected %h", rd, 32'h00000088);
    end
    access(1'b0, 1'b1, 1'b0, LH, 6'h0A, 32'h0, rd, flt, bw);
    checks++;
    if (rd !== 32'hFFFF8899) begin
      errors++; $display("FAIL lh_0a: got %h expected %h", rd, 32'hFFFF8899);
    end
    access(1'b0, 1'b1, 1'b0, LHU, 6'h0A, 32'h0, rd, flt, bw);
    checks++;
    if (rd !== 32'h00008899) begin
      errors++; $display("FAIL lhu_0a: got %h expected %h", rd, 32'h00008899);
    end
    access(1'b0, 1'b1, 1'b0, LB, 6'h09, 32'h0, rd, flt, bw);
    checks++;
    if (rd !== 32'hFFFFFFAA) begin
      errors++; $display("FAIL lb_09: got %h expected %h", rd, 32'hFFFFFFAA);
    end
    access(1'b0, 1'b1, 1'b0, LW, 6'h08, 32'h0, rd, flt, bw);
    checks++;
    if (rd !== 32'h8899AABC || flt !== 1'b0) begin
      errors++; $display("FAIL lw_08: got %h/%b expected %h/0", rd, flt, 32'h8899AABC);
    end
  endtask

  task automatic test_partial_store();
    logic [31:0] rd;
    logic        flt;
    int          bw;
    // Upper bits of store data must not leak into neighbouring lanes.
    access(1'b0, 1'b0, 1'b1, LB, 6'h09, 32'hDEADBE55, rd, flt, bw);
    access(1'b0, 1'b1, 1'b0, LW, 6'h08, 32'h0, rd, flt, bw);
    checks++;
    if (rd !== 32'h889955BC) begin
      errors++; $display("FAIL sb_09_merge: got %h expected %h", rd, 32'h889955BC);
    end
    access(1'b0, 1'b0, 1'b1, LH, 6'h0A, 32'hCAFE1234, rd, flt, bw);
    access(1'b0, 1'b1, 1'b0, LW, 6'h08, 32'h0, rd, flt, bw);
    checks++;
    if (rd !== 32'h123455BC) begin
      errors++; $display("FAIL sh_0a_merge: got %h expected %h", rd, 32'h123455BC);
    end
  endtask

  task automatic test_latency();
    logic [31:0] rd;
    logic        flt;
    int          bw;
    logic [9:0]  pat;
    logic [31:0] r3, r4, r9;
    access(1'b0, 1'b1, 1'b0, LW, 6'h00, 32'h0, rd, flt, bw);
    pat = '0; r3 = '0; r4 = '0; r9 = '0;
    drive(1'b0, 1'b1, 1'b0, LW, 6'h08, 32'h0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      pat[c] = a_busywait;
      if (c == 3) r3 = a_readdata;
      if (c == 4) r4 = a_readdata;
      if (c == 9) r9 = a_readdata;
    end
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 6'h00, 32'h0);
    checks++;
    if (pat !== 10'b0111101111) begin
      errors++; $display("FAIL latency_pattern: got %b expected %b", pat, 10'b0111101111);
    end
    checks++;
    if (r3 !== 32'h0) begin
      errors++; $display("FAIL latency_busy_hold: got %h expected %h", r3, 32'h0);
    end
    checks++;
    if (r4 !== 32'h123455BC) begin
      errors++; $display("FAIL latency_done_data: got %h expected %h", r4, 32'h123455BC);
    end
    checks++;
    if (r9 !== 32'h123455BC) begin
      errors++; $display("FAIL latency_second_data: got %h expected %h", r9, 32'h123455BC);
    end
  endtask

  task automatic test_faults();
    logic [31:0] rd;
    logic        flt;
    int          bw;
    access(1'b0, 1'b1, 1'b0, LW, 6'h08, 32'h0, rd, flt, bw);
    access(1'b0, 1'b1, 1'b0, LW, 6'h02, 32'h0, rd, flt, bw);
    checks++;
    if (flt !== 1'b1 || rd !== 32'h0 || bw != 4) begin
      errors++; $display("FAIL lw_misaligned: got %b/%h/%0d expected 1/00000000/4", flt, rd, bw);
    end
    access(1'b0, 1'b1, 1'b0, LW, 6'h08, 32'h0, rd, flt, bw);
    access(1'b0, 1'b0, 1'b1, LH, 6'h01, 32'h0000FFFF, rd, flt, bw);
    checks++;
    if (flt !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL sh_misaligned: got %b/%h expected 1/00000000", flt, rd);
    end
    access(1'b0, 1'b1, 1'b0, LW, 6'h00, 32'h0, rd, flt, bw);
    checks++;
    if (flt !== 1'b0 || rd !== 32'h0) begin
      errors++; $display("FAIL sh_misaligned_mem: got %b/%h expected 0/00000000", flt, rd);
    end
    access(1'b0, 1'b1, 1'b0, LW, 6'h08, 32'h0, rd, flt, bw);
    access(1'b0, 1'b1, 1'b0, 3'b011, 6'h08, 32'h0, rd, flt, bw);
    checks++;
    if (flt !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL load_f3_011: got %b/%h expected 1/00000000", flt, rd);
    end
    access(1'b0, 1'b0, 1'b1, LBU, 6'h08, 32'h00000000, rd, flt, bw);
    checks++;
    if (flt !== 1'b1) begin
      errors++; $display("FAIL store_f3_100: got %b expected 1", flt);
    end
    access(1'b0, 1'b1, 1'b0, LW, 6'h08, 32'h0, rd, flt, bw);
    checks++;
    if (rd !== 32'h123455BC || flt !== 1'b0) begin
      errors++; $display("FAIL store_f3_100_mem: got %h/%b expected %h/0", rd, flt, 32'h123455BC);
    end
    drive(1'b0, 1'b1, 1'b1, LW, 6'h08, 32'hFFFFFFFF);
    @(negedge clock);
    checks++;
    if (a_busywait !== 1'b0) begin
      errors++; $display("FAIL rw_busywait: got %b expected 0", a_busywait);
    end
    @(posedge clock); #1;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 6'h00, 32'h0);
    @(negedge clock);
    checks++;
    if (a_access_fault !== 1'b1 || a_readdata !== 32'h0) begin
      errors++;
      $display("FAIL rw_done: got %b/%h expected 1/00000000", a_access_fault, a_readdata);
    end
    @(negedge clock);
    checks++;
    if (a_access_fault !== 1'b0) begin
      errors++; $display("FAIL rw_fault_clear: got %b expected 0", a_access_fault);
    end
    @(posedge clock); #1;
    access(1'b0, 1'b1, 1'b0, LW, 6'h08, 32'h0, rd, flt, bw);
    checks++;
    if (rd !== 32'h123455BC) begin
      errors++; $display("FAIL rw_mem: got %h expected %h", rd, 32'h123455BC);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    logic        flt;
    int          bw;
    access(1'b1, 1'b0, 1'b1, LW, 6'h10, 32'hCAFEF00D, rd, flt, bw);
    checks++;
    if (bw != 6) begin
      errors++; $display("FAIL b_sw_busy_cycles: got %0d expected 6", bw);
    end
    access(1'b1, 1'b1, 1'b0, LW, 6'h10, 32'h0, rd, flt, bw);
    checks++;
    if (rd !== 32'hCAFEF00D) begin
      errors++; $display("FAIL b_lw_10: got %h expected %h", rd, 32'hCAFEF00D);
    end
    drive(1'b1, 1'b0, 1'b1, LW, 6'h10, 32'h12345678);
    repeat (3) @(negedge clock);
    checks++;
    if (b_busywait !== 1'b1) begin
      errors++; $display("FAIL b_mid_busy: got %b expected 1", b_busywait);
    end
    @(posedge clock); #1;
    b_reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 3'b000, 6'h00, 32'h0);
    @(posedge clock); #1;
    b_reset = 1'b0;
    @(negedge clock);
    checks++;
    if (b_readdata !== 32'h0 || b_access_fault !== 1'b0 || b_busywait !== 1'b0) begin
      errors++;
      $display("FAIL b_after_reset: got %h/%b/%b expected 00000000/0/0",
               b_readdata, b_access_fault, b_busywait);
    end
    @(posedge clock); #1;
    access(1'b1, 1'b1, 1'b0, LW, 6'h10, 32'h0, rd, flt, bw);
    checks++;
    if (rd !== 32'hCAFEF00D || bw != 6) begin
      errors++; $display("FAIL b_abort_mem: got %h/%0d expected %h/6", rd, bw, 32'hCAFEF00D);
    end
  endtask

  initial begin
    test_reset();
    test_load_store();
    test_partial_store();
    test_latency();
    test_faults();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
